// File: rtl/mips_pkg.sv
// mips_pkg: shared write-back constants and the W pipeline register layout.
package mips_pkg;
   localparam logic [1:0] WDSEL_ALU = 2'b00;
   localparam logic [1:0] WDSEL_DM  = 2'b01;
   localparam logic [1:0] WDSEL_PC8 = 2'b10;
   localparam logic [2:0] LT_LW  = 3'b000;
   localparam logic [2:0] LT_LB  = 3'b001;
   localparam logic [2:0] LT_LBU = 3'b010;
   localparam logic [2:0] LT_LH  = 3'b011;
   localparam logic [2:0] LT_LHU = 3'b100;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic        reg_write;
      logic [4:0]  a3;
      logic [1:0]  wd_sel;
      logic [31:0] alu_out;
      logic [31:0] dm_read;
      logic [2:0]  load_type;
   } w_reg_t;
endpackage

// File: rtl/load_ext.sv
// load_ext: little-endian byte/halfword extraction and sign/zero extension of a DM word.
module load_ext
   import mips_pkg::*;
(
   input  logic [31:0] DMRead,
   input  logic [1:0]  Offset,
   input  logic [2:0]  LoadType,
   output logic [31:0] Data
);
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   assign w_byte = DMRead[{Offset, 3'b000} +: 8];
   assign w_half = Offset[1] ? DMRead[31:16] : DMRead[15:0];
   // Unknown load types fall through to a full-word load.
   always_comb
      Data = (LoadType == LT_LB)  ? {{24{w_byte[7]}}, w_byte} :
             (LoadType == LT_LBU) ? {24'd0, w_byte} :
             (LoadType == LT_LH)  ? {{16{w_half[15]}}, w_half} :
             (LoadType == LT_LHU) ? {16'd0, w_half} : DMRead;
endmodule

// File: rtl/wb_stage.sv
// wb_stage: W pipeline register, write-data select and register-file write port,
// plus W-stage forwarding info and a retired-instruction counter.
module wb_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Stall,
   input  logic        Flush,
   input  logic        M_Valid,
   input  logic [31:0] M_PC,
   input  logic        M_RegWrite,
   input  logic [4:0]  M_A3,
   input  logic [1:0]  M_WDSel,
   input  logic [31:0] M_ALUOut,
   input  logic [31:0] M_DMRead,
   input  logic [2:0]  M_LoadType,
   output logic [31:0] W_PC,
   output logic [4:0]  W_A3,
   output logic [31:0] W_WD,
   output logic        W_WE,
   output logic        W_FwdValid,
   output logic [31:0] W_RetireCnt
);
   w_reg_t      r_w;
   logic [31:0] r_retire_cnt;
   logic [31:0] w_load_data;
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_w          <= '0;
         r_w.pc       <= RESET_PC;
         r_retire_cnt <= '0;
      end else if (!Stall) begin
         r_w          <= Flush ? w_reg_t'('0) :
                         '{M_Valid, M_PC, M_RegWrite, M_A3, M_WDSel, M_ALUOut, M_DMRead, M_LoadType};
         r_retire_cnt <= r_retire_cnt + 32'(r_w.valid);
      end
   end
   load_ext u_load_ext (
      .DMRead  (r_w.dm_read),
      .Offset  (r_w.alu_out[1:0]),
      .LoadType(r_w.load_type),
      .Data    (w_load_data)
   );
   assign W_PC        = r_w.pc;
   assign W_A3        = r_w.a3;
   assign W_WD        = (r_w.wd_sel == WDSEL_DM)  ? w_load_data :
                        (r_w.wd_sel == WDSEL_PC8) ? r_w.pc + 32'd8 : r_w.alu_out;
   // Forwarding ignores Stall; the write itself waits for the edge W is left.
   assign W_FwdValid  = r_w.valid & r_w.reg_write & (r_w.a3 != 5'd0);
   assign W_WE        = W_FwdValid & !Stall;
   assign W_RetireCnt = r_retire_cnt;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed self-checking bench for wb_stage.
module tb_wb_stage;
   import mips_pkg::*;
   logic        Clk = 1'b0;
   logic        Reset, Stall, Flush;
   logic        M_Valid, M_RegWrite;
   logic [31:0] M_PC, M_ALUOut, M_DMRead;
   logic [4:0]  M_A3;
   logic [1:0]  M_WDSel;
   logic [2:0]  M_LoadType;
   logic [31:0] W_PC, W_WD, W_RetireCnt;
   logic [4:0]  W_A3;
   logic        W_WE, W_FwdValid;
   int checks = 0;
   int errors = 0;
   wb_stage dut (
      .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
      .M_Valid(M_Valid), .M_PC(M_PC), .M_RegWrite(M_RegWrite), .M_A3(M_A3),
      .M_WDSel(M_WDSel), .M_ALUOut(M_ALUOut), .M_DMRead(M_DMRead), .M_LoadType(M_LoadType),
      .W_PC(W_PC), .W_A3(W_A3), .W_WD(W_WD), .W_WE(W_WE),
      .W_FwdValid(W_FwdValid), .W_RetireCnt(W_RetireCnt)
   );
   always #5 Clk = ~Clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic tick;
      @(posedge Clk);
      #1;
   endtask
   task automatic setm(input logic v, input logic [31:0] pc, input logic rw, input logic [4:0] a3,
                       input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] dm,
                       input logic [2:0] lt);
      M_Valid = v; M_PC = pc; M_RegWrite = rw; M_A3 = a3;
      M_WDSel = sel; M_ALUOut = alu; M_DMRead = dm; M_LoadType = lt;
   endtask
   task automatic idle;
      setm(1'b0, 32'd0, 1'b0, 5'd0, WDSEL_ALU, 32'd0, 32'd0, LT_LW);
   endtask
   logic [1:0]  ld_off [7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd0};
   logic [2:0]  ld_lt  [7] = '{LT_LB, LT_LB, LT_LB, LT_LB, LT_LBU, LT_LH, LT_LHU};
   logic [31:0] ld_exp [7] = '{32'hFFFF_FFA1, 32'hFFFF_FFF0, 32'h0000_0070, 32'hFFFF_FF80,
                               32'h0000_0080, 32'hFFFF_8070, 32'h0000_F0A1};
   initial begin
      Reset = 1'b1; Stall = 1'b0; Flush = 1'b0;
      idle();
      tick(); tick();
      Reset = 1'b0;
      #1;
      chk("rst_pc", W_PC, 32'h0000_3000);
      chk("rst_a3", 32'(W_A3), 32'd0);
      chk("rst_wd", W_WD, 32'd0);
      chk("rst_we", 32'(W_WE), 32'd0);
      chk("rst_fwd", 32'(W_FwdValid), 32'd0);
      chk("rst_cnt", W_RetireCnt, 32'd0);
      // basic ALU write
      setm(1'b1, 32'h0000_3000, 1'b1, 5'd8, WDSEL_ALU, 32'h1234_5678, 32'd0, LT_LW);
      tick(); idle(); #1;
      chk("alu_we", 32'(W_WE), 32'd1);
      chk("alu_a3", 32'(W_A3), 32'd8);
      chk("alu_wd", W_WD, 32'h1234_5678);
      chk("alu_fwd", 32'(W_FwdValid), 32'd1);
      chk("alu_cnt0", W_RetireCnt, 32'd0);
      tick();
      chk("alu_cnt1", W_RetireCnt, 32'd1);
      chk("bubble_we", 32'(W_WE), 32'd0);
      // load extension
      for (int i = 0; i < 7; i++) begin
         setm(1'b1, 32'h0000_3004, 1'b1, 5'd2, WDSEL_DM, {30'd0, ld_off[i]}, 32'h8070_F0A1, ld_lt[i]);
         tick();
         chk($sformatf("load%0d", i), W_WD, ld_exp[i]);
      end
      idle(); tick();
      chk("load_cnt", W_RetireCnt, 32'd8);
      // JAL link value, including wrap
      setm(1'b1, 32'h0000_3010, 1'b1, 5'd31, WDSEL_PC8, 32'd0, 32'd0, LT_LW);
      tick();
      chk("jal_wd", W_WD, 32'h0000_3018);
      chk("jal_we", 32'(W_WE), 32'd1);
      setm(1'b1, 32'hFFFF_FFFC, 1'b1, 5'd31, WDSEL_PC8, 32'd0, 32'd0, LT_LW);
      tick();
      chk("jal_wrap", W_WD, 32'h0000_0004);
      idle(); tick();
      chk("jal_cnt", W_RetireCnt, 32'd10);
      // A3 = 0
      setm(1'b1, 32'h0000_3020, 1'b1, 5'd0, WDSEL_ALU, 32'h0000_DEAD, 32'd0, LT_LW);
      tick();
      chk("r0_we", 32'(W_WE), 32'd0);
      chk("r0_fwd", 32'(W_FwdValid), 32'd0);
      idle(); tick();
      chk("r0_cnt", W_RetireCnt, 32'd11);
      // three-cycle stall, last cycle with Flush too
      setm(1'b1, 32'h0000_3030, 1'b1, 5'd9, WDSEL_ALU, 32'hCAFE_0001, 32'd0, LT_LW);
      tick(); idle(); Stall = 1'b1; #1;
      chk("stall1_we", 32'(W_WE), 32'd0);
      chk("stall1_fwd", 32'(W_FwdValid), 32'd1);
      tick();
      chk("stall2_we", 32'(W_WE), 32'd0);
      chk("stall2_fwd", 32'(W_FwdValid), 32'd1);
      chk("stall2_a3", 32'(W_A3), 32'd9);
      tick(); Flush = 1'b1; #1;
      chk("stall3_we", 32'(W_WE), 32'd0);
      chk("stall3_fwd", 32'(W_FwdValid), 32'd1);
      tick(); Stall = 1'b0; Flush = 1'b0; #1;
      chk("release_we", 32'(W_WE), 32'd1);
      chk("release_wd", W_WD, 32'hCAFE_0001);
      chk("release_cnt", W_RetireCnt, 32'd11);
      tick();
      chk("release_once", 32'(W_WE), 32'd0);
      chk("release_cnt2", W_RetireCnt, 32'd12);
      // Flush alone
      setm(1'b1, 32'h0000_3040, 1'b1, 5'd10, WDSEL_ALU, 32'h0000_0055, 32'd0, LT_LW);
      Flush = 1'b1;
      tick(); Flush = 1'b0; idle(); #1;
      chk("flush_we", 32'(W_WE), 32'd0);
      chk("flush_fwd", 32'(W_FwdValid), 32'd0);
      tick();
      chk("flush_cnt", W_RetireCnt, 32'd12);
      // back-to-back writes to the same register
      setm(1'b1, 32'h0000_3044, 1'b1, 5'd5, WDSEL_ALU, 32'h0000_0111, 32'd0, LT_LW);
      tick();
      chk("b2b_wd1", W_WD, 32'h0000_0111);
      setm(1'b1, 32'h0000_3048, 1'b1, 5'd5, WDSEL_ALU, 32'h0000_0222, 32'd0, LT_LW);
      tick();
      chk("b2b_wd2", W_WD, 32'h0000_0222);
      chk("b2b_we2", 32'(W_WE), 32'd1);
      // Reset mid-stall
      setm(1'b1, 32'h0000_3050, 1'b1, 5'd11, WDSEL_ALU, 32'h0000_0077, 32'd0, LT_LW);
      tick(); idle(); Stall = 1'b1;
      tick(); Reset = 1'b1; #1;
      chk("rstall_we", 32'(W_WE), 32'd0);
      tick(); Reset = 1'b0; Stall = 1'b0; #1;
      chk("rstall_pc", W_PC, 32'h0000_3000);
      chk("rstall_cnt", W_RetireCnt, 32'd0);
      chk("rstall_we2", 32'(W_WE), 32'd0);
      chk("rstall_fwd", 32'(W_FwdValid), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the five-stage MIPS pipeline, and the sole writer of the general register file. It latches the MEM-stage result bundle into a W pipeline register, selects and extends the write data, and drives the register file's write port (PC, A3, WD, WE). It also exposes the W-stage destination for forwarding and keeps a retired-instruction counter.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, value loaded into W_PC on Reset.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high.
- Stall  in  1  hold the W register; suppresses the write.
- Flush  in  1  load a bubble instead of the M bundle.
- M_Valid  in  1  M bundle holds a real instruction.
- M_PC  in  32  instruction address.
- M_RegWrite  in  1  instruction writes a GPR.
- M_A3  in  5  destination register.
- M_WDSel  in  2  write-data source: 00 ALU, 01 DM, 10 PC+8, 11 reserved (selects ALU).
- M_ALUOut  in  32  ALU result; bits [1:0] are the load byte offset.
- M_DMRead  in  32  aligned word read from DM.
- M_LoadType  in  3  000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu; others are treated as lw.
- W_PC  out  32  PC to the register file.
- W_A3  out  5  write address.
- W_WD  out  32  write data.
- W_WE  out  1  write enable.
- W_FwdValid  out  1  W_WD is forwardable for W_A3.
- W_RetireCnt  out  32  count of retired valid instructions.

## Operation
- W register fields: valid, PC, RegWrite, A3, WDSel, ALUOut, DMRead, LoadType.
- Register update priority at posedge:
  - Reset: valid=0, PC=RESET_PC, all other fields 0, W_RetireCnt=0.
  - Stall: hold every field.
  - Flush: valid=0, RegWrite=0. Other fields don't care; implement them as 0.
  - Otherwise: load the M bundle.
- Write-data select, from the latched fields only:
  - ALU: ALUOut.
  - DM: load-extended DMRead.
  - PC+8: PC + 32'd8, modulo 2^32 (PC 32'hFFFF_FFFC gives 32'h0000_0004).
- Load extension is little-endian:
  - Byte k is DMRead[8k+7:8k], with k = ALUOut[1:0].
  - lb sign-extends the byte; lbu zero-extends it.
  - lh/lhu select the halfword at ALUOut[1] (0 gives [15:0], 1 gives [31:16]), sign- or zero-extended. ALUOut[0] is ignored; the address exception is raised upstream.
- W_WE = valid & RegWrite & (A3 != 0) & !Stall. This makes each instruction write exactly once, on the edge it leaves W. A3 = 0 never asserts W_WE.
- W_FwdValid = valid & RegWrite & (A3 != 0). It is not gated by Stall, so forwarding stays correct while W is held.
- W_RetireCnt increments by 1 on each posedge with valid & !Stall & !Reset. It wraps from 32'hFFFF_FFFF to 0.

## Timing
- M to W latency: 1 cycle. W outputs are combinational from the W register. W_WE also depends combinationally on Stall.
- The register file samples W_WE/W_A3/W_WD on the same posedge that advances W, so an instruction latched at edge n is written at edge n+1 if Stall is low during cycle n+1.
- Outputs after Reset: W_PC=RESET_PC, W_A3=0, W_WD=0, W_WE=0, W_FwdValid=0, W_RetireCnt=0.
- Stall held for k cycles: W_WE stays 0 for those k cycles. The write fires on the first edge with Stall low. The counter increments once.
- Stall and Flush together: Stall wins. The held instruction is not lost.
- Reset in the middle of a stall: the held instruction is discarded, no write, and the counter goes to 0.
- Back-to-back instructions to the same A3: one write per edge, and the later value wins.

## Structure
- Constants live in shared package mips_pkg:
  - WDSEL_ALU/DM/PC8
  - LT_LW/LB/LBU/LH/LHU
  - RESET_PC_DEFAULT
- One combinational sub-module, load_ext: (DMRead, offset[1:0], LoadType) to 32-bit data. All registers, select logic and the counter stay in wb_stage.

## Test plan
- Reset, then idle: all outputs at reset values. M_Valid=1, RegWrite=1, A3=8, WDSel=ALU, ALUOut=32'h1234_5678 gives W_WE=1, W_A3=8, W_WD=32'h1234_5678 in the following cycle; W_RetireCnt becomes 1.
- DMRead=32'h8070_F0A1 with offsets 0..3 under lb gives FFFF_FFA1, FFFF_FFF0, 0000_0070, FFFF_FF80. lbu offset 3 gives 0000_0080. lh offset 2 gives FFFF_8070. lhu offset 0 gives 0000_F0A1.
- JAL bundle with PC=32'h0000_3010, WDSel=PC8, A3=31 gives W_WD=32'h0000_3018. PC=32'hFFFF_FFFC gives W_WD=32'h0000_0004.
- A3=0, RegWrite=1: W_WE=0 and W_FwdValid=0, but the counter still increments.
- Stall for 3 cycles with a valid write in W: W_WE=0 and W_FwdValid=1 for 3 cycles. A single W_WE pulse follows on release. Stall+Flush asserted together preserves the instruction. Flush alone gives W_WE=0 next cycle and no counter increment.
- Reset asserted mid-stall: no write occurs, W_PC=32'h0000_3000, W_RetireCnt=0.
